// File: rtl/spinner_pkg.sv
// Shared widths, direction type and the clamp/wrap helper used by the multi-channel dial spinner.
package spinner_pkg;

  localparam int unsigned SPIN_PKT_W   = 9;
  localparam int unsigned SPIN_DELTA_W = 8;
  localparam int unsigned VEL_W        = 10;
  // One cycle's combined delta: digital step plus signed spinner delta, with headroom
  localparam int unsigned DELTA_W      = SPIN_DELTA_W + 2;
  // Extra signed bits carried above the fine position while summing
  localparam int unsigned SUM_EXT      = 10;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } dir_t;

  // Fold a signed sum back into [0, 2^width-1]: modulo when wrap, else saturate
  function automatic logic [31:0] sat_wrap(input logic signed [31:0] value,
                                           input logic                wrap,
                                           input int unsigned         width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    if (wrap) begin
      sat_wrap = value & mask;
    end else if (value < 0) begin
      sat_wrap = '0;
    end else if (value > $signed(mask)) begin
      sat_wrap = mask;
    end else begin
      sat_wrap = value;
    end
  endfunction

endpackage

// File: rtl/spinner_chan.sv
// One dial channel: button hold-repeat, spinner delta capture, fine position and optional velocity.
// Optional velocity output is built when SPINNER_VEL_EN is defined.
module spinner_chan
  import spinner_pkg::*;
#(
  parameter int unsigned OUT_W      = 4,
  parameter int unsigned RATE_DIV   = 8,
  parameter int unsigned FAST_SHIFT = 2,
  parameter int unsigned SPIN_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  strobe_rise,
  input  logic                  armed,
  input  logic                  minus,
  input  logic                  plus,
  input  logic                  fast,
  input  logic                  wrap_mode,
  input  logic [SPIN_PKT_W-1:0] spin_pkt,
  output logic [OUT_W-1:0]      spin_out,
`ifdef SPINNER_VEL_EN
  output logic [VEL_W-1:0]      vel_out,
`endif
  output logic                  changed
);

  localparam int unsigned FW          = OUT_W + SPIN_SHIFT;
  localparam int unsigned SUM_W       = FW + SUM_EXT;
  localparam int unsigned CNT_W       = $clog2(RATE_DIV) + 1;
  localparam int unsigned FAST_DIV    = RATE_DIV >> FAST_SHIFT;
  localparam int unsigned FAST_PERIOD = (FAST_DIV < 1) ? 1 : FAST_DIV;
  localparam logic signed [DELTA_W-1:0] STEP = DELTA_W'(1 << SPIN_SHIFT);

  dir_t                       dir_c;
  dir_t                       dir_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_next;
  logic [CNT_W-1:0]           period_m1;
  logic                       step_c;
  logic signed [DELTA_W-1:0]  step_delta;
  logic                       toggle;
  logic                       tog_q;
  logic                       spin_ev;
  logic signed [DELTA_W-1:0]  spin_delta;
  logic signed [DELTA_W-1:0]  delta_c;
  logic                       ev_c;
  logic                       ev_q;
  logic signed [DELTA_W-1:0]  delta_q;
  logic [FW-1:0]              fine_q;
  logic signed [SUM_W-1:0]    sum_c;
  logic [FW-1:0]              fine_next;

  assign toggle   = spin_pkt[SPIN_PKT_W-1];
  assign spin_out = fine_q[FW-1:SPIN_SHIFT];

  // Resolve the button pair into a direction; both or neither pressed means idle
  always_comb begin
    dir_c = NONE;
    if (plus && !minus) begin
      dir_c = INC;
    end else if (minus && !plus) begin
      dir_c = DEC;
    end
  end

  // Press edge steps at once; a steady hold steps once every period strobe rises
  always_comb begin
    step_c    = 1'b0;
    cnt_next  = cnt_q;
    period_m1 = fast ? CNT_W'(FAST_PERIOD - 1) : CNT_W'(RATE_DIV - 1);
    if (dir_c == NONE) begin
      cnt_next = '0;
    end else if (dir_c != dir_q) begin
      step_c   = 1'b1;
      cnt_next = '0;
    end else if (strobe_rise) begin
      // >= lets a mid-hold switch to a shorter period fire on the next rise
      if (cnt_q >= period_m1) begin
        step_c   = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_q + CNT_W'(1);
      end
    end
  end

  // Combine the digital step and any new spinner delta into one pending update
  always_comb begin
    step_delta = '0;
    if (step_c) begin
      step_delta = (dir_c == INC) ? STEP : -STEP;
    end
    spin_ev    = armed && (toggle != tog_q);
    spin_delta = '0;
    if (spin_ev) begin
      spin_delta = {{(DELTA_W-SPIN_DELTA_W){spin_pkt[SPIN_DELTA_W-1]}},
                    spin_pkt[SPIN_DELTA_W-1:0]};
    end
    delta_c = step_delta + spin_delta;
    ev_c    = step_c || spin_ev;
  end

  // Input stage: button history, hold counter, toggle history and the pending delta
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q   <= NONE;
      cnt_q   <= '0;
      tog_q   <= 1'b0;
      ev_q    <= 1'b0;
      delta_q <= '0;
    end else begin
      dir_q <= dir_c;
      cnt_q <= cnt_next;
      // Before arming, the toggle is only captured so a stale level is not a delta
      if (!armed || spin_ev) begin
        tog_q <= toggle;
      end
      ev_q    <= ev_c;
      delta_q <= delta_c;
    end
  end

  // Signed sum of the current position and the pending delta, folded by wrap_mode
  always_comb begin
    sum_c = $signed({{(SUM_W-FW){1'b0}}, fine_q})
          + $signed({{(SUM_W-DELTA_W){delta_q[DELTA_W-1]}}, delta_q});
    fine_next = FW'(sat_wrap(32'(sum_c), wrap_mode, FW));
  end

  // Update stage: apply the pending delta and flag integer-part changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fine_q  <= '0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (ev_q) begin
        fine_q  <= fine_next;
        changed <= (fine_next[FW-1:SPIN_SHIFT] != fine_q[FW-1:SPIN_SHIFT]);
      end
    end
  end

`ifdef SPINNER_VEL_EN
  localparam int unsigned ACC_W = VEL_W + 2;
  localparam logic signed [ACC_W-1:0] VEL_MAX = ACC_W'((1 << (VEL_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] VEL_MIN = -VEL_MAX;

  logic signed [VEL_W-1:0] vel_acc;
  logic signed [ACC_W-1:0] applied;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_sat;

  // Saturating running sum of the deltas applied this frame, taken before the clamp
  always_comb begin
    applied = '0;
    if (ev_q) begin
      applied = {{(ACC_W-DELTA_W){delta_q[DELTA_W-1]}}, delta_q};
    end
    acc_sum = {{(ACC_W-VEL_W){vel_acc[VEL_W-1]}}, vel_acc} + applied;
    acc_sat = acc_sum;
    if (acc_sum > VEL_MAX) begin
      acc_sat = VEL_MAX;
    end else if (acc_sum < VEL_MIN) begin
      acc_sat = VEL_MIN;
    end
  end

  // Latch the frame's sum on each strobe rise and restart with this cycle's delta
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vel_acc <= '0;
      vel_out <= '0;
    end else if (strobe_rise) begin
      vel_out <= vel_acc;
      vel_acc <= applied[VEL_W-1:0];
    end else begin
      vel_acc <= acc_sat[VEL_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/spinner_multi.sv
// N-channel dial spinner: shared strobe edge detect and arming, one spinner_chan per channel.
// Optional per-channel velocity output vel_out is built when SPINNER_VEL_EN is defined.
module spinner_multi
  import spinner_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned OUT_W      = 4,
  parameter int unsigned RATE_DIV   = 8,
  parameter int unsigned FAST_SHIFT = 2,
  parameter int unsigned SPIN_SHIFT = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           strobe,
  input  logic [CHANNELS-1:0]            minus,
  input  logic [CHANNELS-1:0]            plus,
  input  logic [CHANNELS-1:0]            fast,
  input  logic [CHANNELS-1:0]            wrap_mode,
  input  logic [CHANNELS*SPIN_PKT_W-1:0] spin_in,
  output logic [CHANNELS*OUT_W-1:0]      spin_out,
`ifdef SPINNER_VEL_EN
  output logic [CHANNELS*VEL_W-1:0]      vel_out,
`endif
  output logic [CHANNELS-1:0]            changed
);

  logic strobe_d;
  logic strobe_rise;
  logic armed;

  assign strobe_rise = strobe & ~strobe_d;

  // Strobe history for edge detect; arming flag set on the first clock after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_d <= 1'b0;
      armed    <= 1'b0;
    end else begin
      strobe_d <= strobe;
      armed    <= 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    spinner_chan #(
      .OUT_W      (OUT_W),
      .RATE_DIV   (RATE_DIV),
      .FAST_SHIFT (FAST_SHIFT),
      .SPIN_SHIFT (SPIN_SHIFT)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .strobe_rise (strobe_rise),
      .armed       (armed),
      .minus       (minus[c]),
      .plus        (plus[c]),
      .fast        (fast[c]),
      .wrap_mode   (wrap_mode[c]),
      .spin_pkt    (spin_in[c*SPIN_PKT_W +: SPIN_PKT_W]),
      .spin_out    (spin_out[c*OUT_W +: OUT_W]),
`ifdef SPINNER_VEL_EN
      .vel_out     (vel_out[c*VEL_W +: VEL_W]),
`endif
      .changed     (changed[c])
    );
  end

endmodule

// File: doc/spinner_multi.md
Name: spinner_multi

Overview:
- Parametrised successor to the single-channel spinner used by the dial games (Kick-style paddle inputs).
- Holds N independent dial positions. Each position is driven by digital minus/plus buttons with hold-repeat on the video strobe, plus a fast modifier. It also takes the MiSTer spinner delta stream, with sub-step fractional resolution.
- Each channel can clamp or wrap its position.
- Sits between the input-mapping logic of the emu top level and the game's input port muxing.

Parameters:
- CHANNELS, 2, number of independent dials.
- OUT_W, 4, width of each position output (angle).
- RATE_DIV, 8, strobe rising edges per repeat step while a button is held.
- FAST_SHIFT, 2, when fast=1 the repeat period is max(1, RATE_DIV>>FAST_SHIFT).
- SPIN_SHIFT, 2, fractional bits: one output step = 2^SPIN_SHIFT spinner counts.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- strobe, in, 1, repeat timebase (vsync level); the rising edge is used.
- minus, in, CHANNELS, per-channel decrement button level.
- plus, in, CHANNELS, per-channel increment button level.
- fast, in, CHANNELS, per-channel fast-repeat select.
- wrap_mode, in, CHANNELS, 1 = modulo wrap, 0 = saturate.
- spin_in, in, CHANNELS*9, per channel {toggle[8], signed delta[7:0]}.
- spin_out, out, CHANNELS*OUT_W, per-channel position (integer part).
- changed, out, CHANNELS, one-cycle pulse when spin_out of that channel changes.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset state:
  - fine positions, spin_out, changed, hold counters, button history and the toggle-armed flag are all 0.
  - Toggle history is captured from spin_in on the first clock after reset deassert, without applying a delta.
- Fine position:
  - Per channel, FW = OUT_W+SPIN_SHIFT bits.
  - spin_out = fine[FW-1:SPIN_SHIFT].
  - Digital step = ±(1<<SPIN_SHIFT).
- Strobe edge: strobe_rise = strobe & ~strobe_d, with strobe_d registered.
- Digital direction dir per channel:
  - +1 if plus & ~minus.
  - -1 if minus & ~plus.
  - 0 otherwise. On 0 the hold counter clears and no step is produced.
- Press edge (dir changes from 0 or opposite to nonzero): the step is applied immediately and the hold counter is cleared.
- Hold:
  - On each strobe_rise with dir unchanged and nonzero, the hold counter increments.
  - When it reaches period-1, a step is applied and the counter clears.
  - period = fast ? max(1, RATE_DIV>>FAST_SHIFT) : RATE_DIV, sampled at each strobe_rise.
  - If fast changes mid-hold and the counter is already ≥ the new period-1, the step fires on the next strobe_rise.
- Spinner: when spin_in toggle differs from its history (and the armed flag is set), the sign-extended delta is added and the history updates.
- Combining events:
  - Digital step and spinner delta in the same cycle are summed into one update.
  - Latency: input event in cycle N → fine/spin_out updated at the end of N+1. changed pulses in N+1 only if the integer part differs.
- Arithmetic: sum computed signed in FW+10 bits.
  - wrap_mode=1: result mod 2^FW.
  - wrap_mode=0: saturate to [0, 2^FW-1].
  - wrap_mode is sampled in the update cycle.
- Channels are fully independent; no arbitration.
- Reset mid-hold returns everything to the reset state, and a still-held button is treated as a new press after reset (one step).

Optional Feature:
- Macro: SPINNER_VEL_EN.
- When defined:
  - Adds output vel_out, CHANNELS*10, signed.
  - Each channel accumulates the sum of all applied fine deltas between strobe rises, before clamp.
  - The sum is latched into vel_out on strobe_rise and the accumulator restarts with that cycle's delta.
  - vel_out resets to 0 and saturates at ±511.
- When undefined: the port and the accumulators are absent; all other behaviour is identical.

Decomposition:
- Package spinner_pkg holds:
  - SPIN_PKT_W=9, SPIN_DELTA_W=8, VEL_W=10.
  - typedef dir_t (enum NONE/INC/DEC).
  - function sat_wrap(value, wrap, width).
- Sub-module spinner_chan holds one channel: hold counter, fine register, toggle history, optional velocity.
- spinner_multi owns the shared strobe edge detect, the reset-armed flag, and the generate loop over CHANNELS.

Test Plan:
All scenarios use default parameters.
- Press/hold: reset; ch0 plus held for 8 strobe rises → spin_out0=1 right after the press, =2 after the 8th rise. changed pulses twice; ch1 stays 0.
- Fast repeat: fast0=1, plus held for 8 rises → spin_out0 goes 1 at press, then +1 every 2 rises, final 5.
- Clamp vs wrap at zero:
  - wrap0=0, press minus at 0 → spin_out0 stays 0, no changed pulse.
  - wrap0=1 → 15, then press plus → 0.
- Spinner fractional input:
  - Toggle with delta +6 → fine 6, out 1.
  - Toggle +2 → out 2.
  - Toggle -128 in clamp mode → 0.
  - No toggle change → no update, including the first cycle after reset with toggle=1.
- Simultaneous and conflicting input:
  - plus and minus both held → no movement.
  - plus press in the same cycle as a spin toggle of +4 → out +2 in one update.
  - Reset asserted mid-hold → out 0 immediately (asynchronous); after release, still-held plus → out 1.
- SPINNER_VEL_EN:
  - Three toggles of +5 between strobes → vel_out0=15 at the next rise.
  - Next frame with no input → 0.
  - Repeated +127 toggles → saturate at 511.
